pipeline_cpu: RTL and testbench

//  Top-level 5-stage (IF/ID/EX/MEM/WB) pipelined MIPS-subset processor; the CPU core of the system.

---
 rtl/cpu_pkg.sv | 67 ++++++
 rtl/reg_file.sv | 36 +++
 rtl/pipeline_cpu.sv | 217 +++++++++++++++++++++
 tb/tb_pipeline_cpu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings, control bundle and pipeline-register layouts for the
// 5-stage MIPS-subset core.
package cpu_pkg;

  localparam int          NUM_REGS = 32;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI   = 6'h0F,
                         OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic MemToReg;
    logic ALUSrc;
    logic RegDst;
    logic Branch;
    logic Jump;
    logic Link;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic        we, mrd, mwr, m2r, alusrc, branch, bne, jump, jreg, link;
    alu_op_e     aop;
    logic [4:0]  rs, rt, dst, shamt;
    logic [31:0] a, b, imm, pc4;
  } idex_t;

  typedef struct packed {
    logic        we, mrd, mwr, m2r;
    logic [4:0]  dst;
    logic [31:0] result, wdata;
  } exmem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
  } memwb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two async read ports, one write port; $0 is hardwired
// to zero and a same-cycle write is passed straight through to the readers.
module reg_file
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == 5'd0) rd1_o = '0;
    if (ra2_i == 5'd0) rd2_o = '0;
  end

endmodule

// File: rtl/pipeline_cpu.sv
// 5-stage MIPS-subset core: ROM fetch, forwarding, load-use stall, j/jal
// resolved in ID, branches and jr/jalr resolved in EX, no delay slot.
module pipeline_cpu
  import cpu_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "inst.hex",
  parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] MemBus_Address,
  input  logic [31:0] Device_Read_Data,
  output logic [31:0] MemBus_Write_Data,
  output logic        MemRead,
  output logic        MemWrite
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d, if_instr;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  // IF
  assign if_instr = ({2'b00, pc_q[31:2]} < IMEM_DEPTH) ? imem[pc_q[IMEM_AW+1:2]] : NOP;

  // ID
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  logic [15:0] id_imm;
  logic [31:0] id_rs_val, id_rt_val, id_imm_ext, id_jtarget;
  ctrl_t       id_ctrl;
  alu_op_e     id_aop;
  logic        id_zext, id_bne, id_jreg, id_jump, load_use;

  assign id_op    = ifid_q.instr[31:26];
  assign id_rs    = ifid_q.instr[25:21];
  assign id_rt    = ifid_q.instr[20:16];
  assign id_rd    = ifid_q.instr[15:11];
  assign id_funct = ifid_q.instr[5:0];
  assign id_imm   = ifid_q.instr[15:0];

  always_comb begin
    id_ctrl = CTRL_NOP;
    id_aop  = ALU_ADD;
    id_zext = 1'b0;
    id_bne  = 1'b0;
    id_jreg = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        id_ctrl.RegWrite = 1'b1;
        id_ctrl.RegDst   = 1'b1;
        case (id_funct)
          FN_SLL:          id_aop = ALU_SLL;
          FN_SRL:          id_aop = ALU_SRL;
          FN_SRA:          id_aop = ALU_SRA;
          FN_ADD, FN_ADDU: id_aop = ALU_ADD;
          FN_SUB, FN_SUBU: id_aop = ALU_SUB;
          FN_AND:          id_aop = ALU_AND;
          FN_OR:           id_aop = ALU_OR;
          FN_XOR:          id_aop = ALU_XOR;
          FN_NOR:          id_aop = ALU_NOR;
          FN_SLT:          id_aop = ALU_SLT;
          FN_SLTU:         id_aop = ALU_SLTU;
          FN_JR: begin
            id_ctrl.RegWrite = 1'b0;
            id_ctrl.Jump     = 1'b1;
            id_jreg          = 1'b1;
          end
          FN_JALR: begin
            id_ctrl.Jump = 1'b1;
            id_ctrl.Link = 1'b1;
            id_jreg      = 1'b1;
          end
          default: id_ctrl = CTRL_NOP;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; end
      OP_SLTI:  begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; id_aop = ALU_SLT;  end
      OP_SLTIU: begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; id_aop = ALU_SLTU; end
      OP_ANDI:  begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; id_aop = ALU_AND; id_zext = 1'b1; end
      OP_ORI:   begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; id_aop = ALU_OR;  id_zext = 1'b1; end
      OP_LUI:   begin id_ctrl.RegWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; id_aop = ALU_LUI; end
      OP_LW: begin
        id_ctrl.RegWrite = 1'b1;
        id_ctrl.MemRead  = 1'b1;
        id_ctrl.MemToReg = 1'b1;
        id_ctrl.ALUSrc   = 1'b1;
      end
      OP_SW:  begin id_ctrl.MemWrite = 1'b1; id_ctrl.ALUSrc = 1'b1; end
      OP_BEQ: id_ctrl.Branch = 1'b1;
      OP_BNE: begin id_ctrl.Branch = 1'b1; id_bne = 1'b1; end
      OP_J:   id_ctrl.Jump = 1'b1;
      OP_JAL: begin id_ctrl.Jump = 1'b1; id_ctrl.Link = 1'b1; id_ctrl.RegWrite = 1'b1; end
      default: ;
    endcase
  end

  assign id_dst     = id_ctrl.RegDst ? id_rd : (id_ctrl.Link ? 5'd31 : id_rt);
  assign id_imm_ext = id_zext ? {16'h0000, id_imm} : sext16(id_imm);
  assign id_jtarget = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
  assign id_jump    = id_ctrl.Jump && !id_jreg;
  assign load_use   = idex_q.mrd && idex_q.dst != 5'd0 &&
                      (idex_q.dst == id_rs || idex_q.dst == id_rt);

  reg_file u_reg_file (
    .clk_i (clk),
    .rst_i (reset),
    .ra1_i (id_rs),
    .ra2_i (id_rt),
    .we_i  (memwb_q.we),
    .wa_i  (memwb_q.dst),
    .wd_i  (memwb_q.data),
    .rd1_o (id_rs_val),
    .rd2_o (id_rt_val)
  );

  // EX
  logic [31:0]        ex_a, ex_b, ex_opb, alu_y, ex_target;
  logic signed [31:0] ex_a_s, ex_opb_s;
  logic               ex_redirect;

  always_comb begin
    ex_a = idex_q.a;
    if (exmem_q.we && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rs)     ex_a = exmem_q.result;
    else if (memwb_q.we && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rs) ex_a = memwb_q.data;
    ex_b = idex_q.b;
    if (exmem_q.we && exmem_q.dst != 5'd0 && exmem_q.dst == idex_q.rt)     ex_b = exmem_q.result;
    else if (memwb_q.we && memwb_q.dst != 5'd0 && memwb_q.dst == idex_q.rt) ex_b = memwb_q.data;
  end

  assign ex_opb   = idex_q.alusrc ? idex_q.imm : ex_b;
  assign ex_a_s   = ex_a;
  assign ex_opb_s = ex_opb;

  always_comb begin
    alu_y = '0;
    case (idex_q.aop)
      ALU_ADD:  alu_y = ex_a + ex_opb;
      ALU_SUB:  alu_y = ex_a - ex_opb;
      ALU_AND:  alu_y = ex_a & ex_opb;
      ALU_OR:   alu_y = ex_a | ex_opb;
      ALU_XOR:  alu_y = ex_a ^ ex_opb;
      ALU_NOR:  alu_y = ~(ex_a | ex_opb);
      ALU_SLT:  alu_y = {31'b0, ex_a_s < ex_opb_s};
      ALU_SLTU: alu_y = {31'b0, ex_a < ex_opb};
      ALU_SLL:  alu_y = ex_opb << idex_q.shamt;
      ALU_SRL:  alu_y = ex_opb >> idex_q.shamt;
      ALU_SRA:  alu_y = ex_opb_s >>> idex_q.shamt;
      ALU_LUI:  alu_y = {ex_opb[15:0], 16'h0000};
      default:  alu_y = '0;
    endcase
  end

  assign ex_redirect = (idex_q.branch && ((ex_a == ex_b) ^ idex_q.bne)) ||
                       (idex_q.jump && idex_q.jreg);
  assign ex_target   = idex_q.jreg ? ex_a : idex_q.pc4 + (idex_q.imm << 2);

  // Next-state selection: EX redirect beats ID jump beats load-use stall
  always_comb begin
    pc_d   = pc_q + 32'd4;
    ifid_d = '{instr: if_instr, pc4: pc_q + 32'd4};
    idex_d = '{we: id_ctrl.RegWrite, mrd: id_ctrl.MemRead, mwr: id_ctrl.MemWrite,
               m2r: id_ctrl.MemToReg, alusrc: id_ctrl.ALUSrc, branch: id_ctrl.Branch,
               bne: id_bne, jump: id_ctrl.Jump, jreg: id_jreg, link: id_ctrl.Link,
               aop: id_aop, rs: id_rs, rt: id_rt, dst: id_dst,
               shamt: ifid_q.instr[10:6], a: id_rs_val, b: id_rt_val,
               imm: id_imm_ext, pc4: ifid_q.pc4};
    if (ex_redirect) begin
      pc_d   = ex_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (id_jump) begin
      pc_d   = id_jtarget;
      ifid_d = '0;
    end else if (load_use) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  assign exmem_d = '{we: idex_q.we, mrd: idex_q.mrd, mwr: idex_q.mwr, m2r: idex_q.m2r,
                     dst: idex_q.dst, result: idex_q.link ? idex_q.pc4 : alu_y,
                     wdata: ex_b};

  // MEM
  assign memwb_d = '{we: exmem_q.we, dst: exmem_q.dst,
                     data: exmem_q.m2r ? Device_Read_Data : exmem_q.result};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign MemBus_Address    = exmem_q.result;
  assign MemBus_Write_Data = exmem_q.wdata;
  assign MemRead           = exmem_q.mrd;
  assign MemWrite          = exmem_q.mwr;

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed-program bench for pipeline_cpu: loads small programs into the ROM,
// models data memory and checks the store traffic on the bus.
module tb_pipeline_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] MemBus_Address;
  logic [31:0] Device_Read_Data;
  logic [31:0] MemBus_Write_Data;
  logic        MemRead;
  logic        MemWrite;

  logic [31:0] dmem [256];

  int n_cmp;
  int n_bad;
  int cyc;
  int rd_cnt;
  logic [31:0] st_addr [$];
  logic [31:0] st_data [$];
  int          st_cyc  [$];

  pipeline_cpu #(
    .IMEM_DEPTH (256),
    .IMEM_FILE  (""),
    .PC_RESET   (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .MemBus_Address    (MemBus_Address),
    .Device_Read_Data  (Device_Read_Data),
    .MemBus_Write_Data (MemBus_Write_Data),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite)
  );

  assign Device_Read_Data = dmem[MemBus_Address[9:2]];

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] j_t(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_store(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d, input int c);
    logic [31:0] ga, gd, gc;
    ga = 32'hDEAD_BEEF;
    gd = 32'hDEAD_BEEF;
    gc = 32'hFFFF_FFFF;
    if (idx < st_addr.size()) begin
      ga = st_addr[idx];
      gd = st_data[idx];
      gc = 32'(st_cyc[idx]);
    end
    check_eq({tag, ".addr"}, ga, a);
    check_eq({tag, ".data"}, gd, d);
    check_eq({tag, ".cycle"}, gc, 32'(c));
  endtask

  // Hold reset, wipe the ROM and the store log
  task automatic new_prog();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    st_addr.delete();
    st_data.delete();
    st_cyc.delete();
  endtask

  task automatic go();
    @(negedge clk);
    reset  = 1'b0;
    cyc    = 0;
    rd_cnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (MemWrite) begin
        st_addr.push_back(MemBus_Address);
        st_data.push_back(MemBus_Write_Data);
        st_cyc.push_back(cyc);
      end
      if (MemRead) rd_cnt++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[0] = 32'h0000_1234;

    // Forwarding program, with power-on reset state checked first
    new_prog();
    dut.imem[0] = i_t(6'h08, 5'd0, 5'd1, 16'd5);
    dut.imem[1] = i_t(6'h08, 5'd1, 5'd2, 16'd3);
    dut.imem[2] = i_t(6'h2B, 5'd0, 5'd2, 16'd4);
    #60;
    check_eq("por.MemRead",  {31'b0, MemRead},  32'h0);
    check_eq("por.MemWrite", {31'b0, MemWrite}, 32'h0);
    check_eq("por.Address",  MemBus_Address,    32'h0);
    check_eq("por.WData",    MemBus_Write_Data, 32'h0);
    go();
    run(5);
    check_eq("fwd.MemWrite_now", {31'b0, MemWrite}, 32'h1);
    check_eq("fwd.count", 32'(st_addr.size()), 32'd1);
    check_store("fwd.st0", 0, 32'd4, 32'd8, 5);

    // Reset asserted mid-run while the sw sits in MEM
    reset = 1'b1;
    #1;
    check_eq("rst.MemWrite", {31'b0, MemWrite}, 32'h0);
    check_eq("rst.MemRead",  {31'b0, MemRead},  32'h0);
    check_eq("rst.Address",  MemBus_Address,    32'h0);
    check_eq("rst.WData",    MemBus_Write_Data, 32'h0);
    new_prog();
    dut.imem[0] = i_t(6'h2B, 5'd0, 5'd2, 16'd44);
    go();
    run(8);
    check_eq("rst.count", 32'(st_addr.size()), 32'd1);
    check_store("rst.st0", 0, 32'd44, 32'd0, 3);

    // Load-use
    new_prog();
    dut.imem[0] = i_t(6'h23, 5'd0, 5'd3, 16'd0);
    dut.imem[1] = r_t(5'd3, 5'd3, 5'd4, 5'd0, 6'h21);
    dut.imem[2] = i_t(6'h2B, 5'd0, 5'd4, 16'd8);
    go();
    run(12);
    check_eq("lu.count", 32'(st_addr.size()), 32'd1);
    check_eq("lu.reads", 32'(rd_cnt), 32'd1);
    check_store("lu.st0", 0, 32'd8, 32'h0000_2468, 6);

    // Taken branch flushes the two following stores
    new_prog();
    dut.imem[0] = i_t(6'h08, 5'd0, 5'd8, 16'h0055);
    dut.imem[1] = i_t(6'h04, 5'd0, 5'd0, 16'd2);
    dut.imem[2] = i_t(6'h2B, 5'd0, 5'd8, 16'd16);
    dut.imem[3] = i_t(6'h2B, 5'd0, 5'd8, 16'd20);
    dut.imem[4] = i_t(6'h2B, 5'd0, 5'd8, 16'd24);
    go();
    run(14);
    check_eq("br.count", 32'(st_addr.size()), 32'd1);
    check_store("br.st0", 0, 32'd24, 32'h0000_0055, 7);

    // jal / jr round trip, then a self-looping j
    new_prog();
    dut.imem[0] = j_t(6'h03, 26'd4);
    dut.imem[1] = i_t(6'h08, 5'd0, 5'd9, 16'h0077);
    dut.imem[2] = i_t(6'h2B, 5'd0, 5'd9, 16'd28);
    dut.imem[3] = j_t(6'h02, 26'd3);
    dut.imem[4] = i_t(6'h2B, 5'd0, 5'd31, 16'd12);
    dut.imem[5] = r_t(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    go();
    run(24);
    check_eq("call.count", 32'(st_addr.size()), 32'd2);
    check_store("call.st0", 0, 32'd12, 32'd4, 5);
    check_store("call.st1", 1, 32'd28, 32'h0000_0077, 10);

    // lui / sra / sltu
    new_prog();
    dut.imem[0] = i_t(6'h0F, 5'd0, 5'd5, 16'h8000);
    dut.imem[1] = r_t(5'd0, 5'd5, 5'd6, 5'd4, 6'h03);
    dut.imem[2] = r_t(5'd0, 5'd5, 5'd7, 5'd0, 6'h2B);
    dut.imem[3] = i_t(6'h2B, 5'd0, 5'd6, 16'd32);
    dut.imem[4] = i_t(6'h2B, 5'd0, 5'd7, 16'd36);
    go();
    run(14);
    check_eq("lsh.count", 32'(st_addr.size()), 32'd2);
    check_store("lsh.st0", 0, 32'd32, 32'hF800_0000, 6);
    check_store("lsh.st1", 1, 32'd36, 32'h0000_0001, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
